// File: rtl/serial_xfer_sched.sv
// ---------------------------------------------------------------------------
// serial_xfer_sched
//
// Schedules single-byte transfers over the serial link registers
// (SB = 0xFF01, SC = 0xFF02) on behalf of two requesters:
//   requester 0 : debug bridge
//   requester 1 : DMA-style test host
//
// One requester is picked at a time by round-robin arbitration. The
// scheduler then borrows the FFxx register bus from the CPU and runs:
//   write SB <= tx byte
//   write SC <= {1, 000000, intclk}   (starts the shifter)
//   release the bus and wait for the serial-complete interrupt
//   re-acquire the bus and read SB      (received byte)
// If the interrupt does not arrive within TIMEOUT cycles, the shifter is
// stopped by writing SC <= 0x00, and the transfer completes with
// rx_data = 0xFF and timeout = 1.
//
// Parameters
//   TIMEOUT_W   width of the wait-for-interrupt counter
//   TIMEOUT     cycles spent waiting before the transfer is aborted
//
// Ports
//   clk         block clock, all state on the rising edge
//   nreset      asynchronous reset, active low
//   req[1:0]    per-requester request, held until its ack pulse
//   req_tx0/1   transmit byte of requester 0 / 1
//   req_intclk  per-requester clock select (1 = internal, SC = 0x81)
//   ack[1:0]    one-hot, 1-cycle completion pulse to the served requester
//   rx_data     received byte, valid with ack, held until the next ack
//   timeout     valid with ack, 1 = transfer aborted (rx_data = 0xFF)
//   bus_req     request for the FFxx register bus
//   bus_gnt     bus granted; held by the arbiter while bus_req is high
//   bus_a       register address
//   bus_d_out   write data
//   bus_d_in    read data, sampled at the end of the read cycle
//   bus_wr      1-cycle write strobe
//   bus_rd      1-cycle read strobe
//   int_serial  serial-complete level from the link, asynchronous to clk
// ---------------------------------------------------------------------------
module serial_xfer_sched #(
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [1:0]  req,
  input  logic [7:0]  req_tx0,
  input  logic [7:0]  req_tx1,
  input  logic [1:0]  req_intclk,
  output logic [1:0]  ack,
  output logic [7:0]  rx_data,
  output logic        timeout,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d_out,
  input  logic [7:0]  bus_d_in,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic        int_serial
);

  localparam logic [15:0] SB_ADDR = 16'hFF01;
  localparam logic [15:0] SC_ADDR = 16'hFF02;

  // Last count value of the WAIT state; reaching it without an interrupt
  // aborts the transfer.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_IDLE,      // arbitrate between requesters
    ST_ARB_SB,    // bus requested, waiting for grant before SB write
    ST_WR_SB,     // SB write strobe on the bus
    ST_WR_SC,     // SC write strobe on the bus (starts the shifter)
    ST_WAIT,      // bus released, waiting for serial-complete
    ST_ARB_RD,    // bus requested, waiting for grant before SB read
    ST_RD_SB,     // SB read strobe on the bus
    ST_ABORT,     // timed out, bus requested for the SC stop write
    ST_ABORT_WR,  // SC <= 0x00 write strobe on the bus
    ST_DONE       // ack pulse to the served requester
  } state_t;

  state_t                state;
  logic                  rr_last;    // requester granted most recently
  logic                  granted;    // requester being served
  logic [7:0]            tx_q;       // tx byte latched at grant
  logic                  intclk_q;   // clock select latched at grant
  logic [TIMEOUT_W-1:0]  wait_cnt;

  // -------------------------------------------------------------------------
  // int_serial synchroniser and rising-edge detector.
  // int_s1/int_s2 bring the level into the clk domain; int_s3 is the
  // previous synced value. int_rise is a registered one-cycle pulse on each
  // synced 0->1 transition. Because edges are tracked continuously, a level
  // that was already high before WAIT produces no pulse inside WAIT: only a
  // fresh rising edge completes a transfer.
  // -------------------------------------------------------------------------
  logic int_s1, int_s2, int_s3, int_rise;

  // NOTE: every flop here, including the synchroniser, uses non-blocking
  // assignments so all registers update together from pre-edge values;
  // blocking assignments would collapse the two synchroniser stages into one.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      int_s1   <= 1'b0;
      int_s2   <= 1'b0;
      int_s3   <= 1'b0;
      int_rise <= 1'b0;
    end else begin
      int_s1   <= int_serial;
      int_s2   <= int_s1;
      int_s3   <= int_s2;
      int_rise <= int_s2 & ~int_s3;
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pick. A lone requester always wins; on a tie the requester
  // that was not served last wins. rr_last resets to 1 so requester 0 wins
  // the first tie.
  // -------------------------------------------------------------------------
  logic grant_sel;

  // NOTE: grant_sel gets a default before any condition so that no path
  // through this block leaves it unassigned, which would infer a latch.
  always_comb begin
    grant_sel = 1'b0;
    if (req == 2'b11) begin
      grant_sel = ~rr_last;
    end else begin
      grant_sel = req[1];
    end
  end

  // One-hot ack for the requester being served.
  logic [1:0] ack_onehot;
  assign ack_onehot = granted ? 2'b10 : 2'b01;

  // -------------------------------------------------------------------------
  // Transfer sequencer. All bus and handshake outputs are registered: the
  // value for a state is loaded on the edge that enters it, so strobes are
  // high exactly during the state they belong to.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      ack       <= 2'b00;
      rx_data   <= 8'h00;
      timeout   <= 1'b0;
      bus_req   <= 1'b0;
      bus_a     <= 16'h0000;
      bus_d_out <= 8'h00;
      bus_wr    <= 1'b0;
      bus_rd    <= 1'b0;
      rr_last   <= 1'b1;
      granted   <= 1'b0;
      tx_q      <= 8'h00;
      intclk_q  <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      // Strobes and ack are single-cycle pulses unless a state re-asserts
      // them below.
      bus_wr <= 1'b0;
      bus_rd <= 1'b0;
      ack    <= 2'b00;

      case (state)
        ST_IDLE: begin
          if (|req) begin
            // Request data is captured here; later changes on req or the
            // tx inputs do not affect the transfer in flight.
            granted  <= grant_sel;
            rr_last  <= grant_sel;
            tx_q     <= grant_sel ? req_tx1 : req_tx0;
            intclk_q <= req_intclk[grant_sel];
            bus_req  <= 1'b1;
            state    <= ST_ARB_SB;
          end
        end

        ST_ARB_SB: begin
          if (bus_gnt) begin
            bus_a     <= SB_ADDR;
            bus_d_out <= tx_q;
            bus_wr    <= 1'b1;
            state     <= ST_WR_SB;
          end
        end

        ST_WR_SB: begin
          bus_a     <= SC_ADDR;
          bus_d_out <= {1'b1, 6'b000000, intclk_q};
          bus_wr    <= 1'b1;
          state     <= ST_WR_SC;
        end

        ST_WR_SC: begin
          // Hand the bus back to the CPU while the byte shifts.
          bus_req  <= 1'b0;
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (int_rise) begin
            bus_req <= 1'b1;
            state   <= ST_ARB_RD;
          end else if (wait_cnt == WAIT_LAST) begin
            bus_req <= 1'b1;
            state   <= ST_ABORT;
          end else begin
            // Increment stops at WAIT_LAST, so the counter never wraps.
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_ARB_RD: begin
          if (bus_gnt) begin
            bus_a  <= SB_ADDR;
            bus_rd <= 1'b1;
            state  <= ST_RD_SB;
          end
        end

        ST_RD_SB: begin
          rx_data <= bus_d_in;
          timeout <= 1'b0;
          bus_req <= 1'b0;
          ack     <= ack_onehot;
          state   <= ST_DONE;
        end

        ST_ABORT: begin
          if (bus_gnt) begin
            // Clearing SC stops the shifter so the link is idle again.
            bus_a     <= SC_ADDR;
            bus_d_out <= 8'h00;
            bus_wr    <= 1'b1;
            state     <= ST_ABORT_WR;
          end
        end

        ST_ABORT_WR: begin
          rx_data <= 8'hFF;
          timeout <= 1'b1;
          bus_req <= 1'b0;
          ack     <= ack_onehot;
          state   <= ST_DONE;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          bus_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_xfer_sched.sv
// ---------------------------------------------------------------------------
// tb_serial_xfer_sched
//
// Scoreboard bench for serial_xfer_sched. Stimulus pushes the expected bus
// writes and ack responses into queues; a monitor pops and compares them
// whenever a DUT presents a bus write or an ack. A small link model raises
// int_serial a fixed number of cycles after each SC start write, or follows
// a level set directly by the stimulus.
//
// Two instances share the inputs: dut (TIMEOUT = 64) carries the normal
// transfers, dut_t (TIMEOUT = 16, own req) is only requested in the
// timeout scenario.
// ---------------------------------------------------------------------------
module tb_serial_xfer_sched;

  logic        clk;
  logic        nreset;
  logic [1:0]  req;
  logic [1:0]  req_t;
  logic [7:0]  req_tx0;
  logic [7:0]  req_tx1;
  logic [1:0]  req_intclk;
  logic        bus_gnt;
  logic [7:0]  bus_d_in;
  logic        int_serial;

  logic [1:0]  ack;
  logic [7:0]  rx_data;
  logic        timeout;
  logic        bus_req;
  logic [15:0] bus_a;
  logic [7:0]  bus_d_out;
  logic        bus_wr;
  logic        bus_rd;

  logic [1:0]  t_ack;
  logic [7:0]  t_rx_data;
  logic        t_timeout;
  logic        t_bus_req;
  logic [15:0] t_bus_a;
  logic [7:0]  t_bus_d_out;
  logic        t_bus_wr;
  logic        t_bus_rd;

  serial_xfer_sched #(.TIMEOUT_W(16), .TIMEOUT(64)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .req        (req),
    .req_tx0    (req_tx0),
    .req_tx1    (req_tx1),
    .req_intclk (req_intclk),
    .ack        (ack),
    .rx_data    (rx_data),
    .timeout    (timeout),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_a      (bus_a),
    .bus_d_out  (bus_d_out),
    .bus_d_in   (bus_d_in),
    .bus_wr     (bus_wr),
    .bus_rd     (bus_rd),
    .int_serial (int_serial)
  );

  serial_xfer_sched #(.TIMEOUT_W(16), .TIMEOUT(16)) dut_t (
    .clk        (clk),
    .nreset     (nreset),
    .req        (req_t),
    .req_tx0    (req_tx0),
    .req_tx1    (req_tx1),
    .req_intclk (req_intclk),
    .ack        (t_ack),
    .rx_data    (t_rx_data),
    .timeout    (t_timeout),
    .bus_req    (t_bus_req),
    .bus_gnt    (bus_gnt),
    .bus_a      (t_bus_a),
    .bus_d_out  (t_bus_d_out),
    .bus_d_in   (bus_d_in),
    .bus_wr     (t_bus_wr),
    .bus_rd     (t_bus_rd),
    .int_serial (int_serial)
  );

  // -------------------------------------------------------------------------
  // Clock, cycle counter, bookkeeping
  // -------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected {addr, data} per bus write and {ack, rx_data, timeout} per ack.
  logic [23:0] wq[$];
  logic [10:0] aq[$];
  logic [23:0] twq[$];
  logic [10:0] taq[$];

  int ack_cnt = 0;
  int t_ack_cnt = 0;
  int wr_cnt = 0;
  int sc_cnt = 0;
  int last_sb_cyc = 0;
  int last_sc_cyc = 0;
  int last_ack_cyc = 0;
  int t_last_sc_cyc = 0;
  int t_last_ack_cyc = 0;

  // Link model controls.
  bit link_auto = 1'b1;
  bit int_manual = 1'b0;
  int link_delay = 6;
  int int_due = -1000;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to 1 ns after the next rising edge: the point where inputs move.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acks(input bit use_t, input int target, input int budget,
                           input string name);
    int k = 0;
    while (((use_t ? t_ack_cnt : ack_cnt) < target) && (k < budget)) begin
      tick(1);
      k++;
    end
    check(name, 32'((use_t ? t_ack_cnt : ack_cnt) >= target), 32'd1);
  endtask

  task automatic wait_sc(input int target, input int budget, input string name);
    int k = 0;
    while ((sc_cnt < target) && (k < budget)) begin
      tick(1);
      k++;
    end
    check(name, 32'(sc_cnt >= target), 32'd1);
  endtask

  // -------------------------------------------------------------------------
  // Link model: sole driver of int_serial.
  // -------------------------------------------------------------------------
  initial begin
    int_serial = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (link_auto) begin
        if (cyc == int_due) int_serial = 1'b1;
        else if (cyc == int_due + 4) int_serial = 1'b0;
      end else begin
        int_serial = int_manual;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: samples on the falling edge, pops and compares.
  // -------------------------------------------------------------------------
  initial begin
    logic [23:0] ew;
    logic [10:0] ea;
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (bus_wr || bus_rd) check("strobe_needs_gnt", 32'(bus_gnt), 32'd1);
        if (bus_wr) begin
          wr_cnt++;
          check("wr_expected", 32'(wq.size() != 0), 32'd1);
          if (wq.size() != 0) begin
            ew = wq.pop_front();
            check("bus_write", {8'h00, bus_a, bus_d_out}, {8'h00, ew});
          end
          if (bus_a == 16'hFF01) last_sb_cyc = cyc;
          if (bus_a == 16'hFF02 && bus_d_out[7]) begin
            last_sc_cyc = cyc;
            sc_cnt++;
            int_due = cyc + link_delay;
          end
        end
        if (ack != 2'b00) begin
          ack_cnt++;
          last_ack_cyc = cyc;
          check("ack_expected", 32'(aq.size() != 0), 32'd1);
          if (aq.size() != 0) begin
            ea = aq.pop_front();
            check("ack_resp", {21'h0, ack, rx_data, timeout}, {21'h0, ea});
          end
        end

        if (t_bus_wr || t_bus_rd) check("t_strobe_needs_gnt", 32'(bus_gnt), 32'd1);
        if (t_bus_wr) begin
          check("t_wr_expected", 32'(twq.size() != 0), 32'd1);
          if (twq.size() != 0) begin
            ew = twq.pop_front();
            check("t_bus_write", {8'h00, t_bus_a, t_bus_d_out}, {8'h00, ew});
          end
          if (t_bus_a == 16'hFF02 && t_bus_d_out[7]) t_last_sc_cyc = cyc;
        end
        if (t_ack != 2'b00) begin
          t_ack_cnt++;
          t_last_ack_cyc = cyc;
          check("t_ack_expected", 32'(taq.size() != 0), 32'd1);
          if (taq.size() != 0) begin
            ea = taq.pop_front();
            check("t_ack_resp", {21'h0, t_ack, t_rx_data, t_timeout}, {21'h0, ea});
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int req_cyc;
    int gnt_cyc;
    int first_ack;
    int a0;
    int w0;
    int low_cnt;

    nreset     = 1'b0;
    req        = 2'b00;
    req_t      = 2'b00;
    req_tx0    = 8'h00;
    req_tx1    = 8'h00;
    req_intclk = 2'b00;
    bus_gnt    = 1'b1;
    bus_d_in   = 8'h00;
    tick(3);
    nreset = 1'b1;
    tick(2);

    // Reset state
    check("rst_ack_timeout_strobes", {27'h0, ack, timeout, bus_req, bus_wr, bus_rd}, 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_bus_a_d", {8'h00, bus_a, bus_d_out}, 32'h0);

    // T1: single transfer, interrupt 20 cycles after the SC write
    link_auto = 1'b1;
    link_delay = 20;
    bus_d_in = 8'h3C;
    req_tx0 = 8'hA5;
    req_intclk = 2'b01;
    wq.push_back({16'hFF01, 8'hA5});
    wq.push_back({16'hFF02, 8'h81});
    aq.push_back({2'b01, 8'h3C, 1'b0});
    req = 2'b01;
    req_cyc = cyc;
    wait_acks(1'b0, 1, 80, "t1_ack_seen");
    req = 2'b00;
    check("t1_req_to_sb", 32'(last_sb_cyc - req_cyc), 32'd2);
    check("t1_sc_to_ack", 32'(last_ack_cyc - last_sc_cyc), 32'd26);
    tick(3);
    check("t1_rx_hold", {23'h0, rx_data, timeout}, {23'h0, 8'h3C, 1'b0});

    // Fresh arbitration history for the tie below
    nreset = 1'b0;
    tick(2);
    nreset = 1'b1;
    tick(2);

    // T2: both requesters held; req0 first, req1 after one idle cycle
    link_delay = 6;
    bus_d_in = 8'h11;
    req_tx0 = 8'hC0;
    req_tx1 = 8'h0F;
    req_intclk = 2'b10;
    wq.push_back({16'hFF01, 8'hC0});
    wq.push_back({16'hFF02, 8'h80});
    aq.push_back({2'b01, 8'h11, 1'b0});
    wq.push_back({16'hFF01, 8'h0F});
    wq.push_back({16'hFF02, 8'h81});
    aq.push_back({2'b10, 8'h22, 1'b0});
    req = 2'b11;
    wait_acks(1'b0, ack_cnt + 1, 60, "t2_first_ack_seen");
    first_ack = last_ack_cyc;
    req = 2'b10;
    bus_d_in = 8'h22;
    wait_acks(1'b0, ack_cnt + 1, 60, "t2_second_ack_seen");
    req = 2'b00;
    check("t2_back_to_back", 32'(last_sb_cyc - first_ack), 32'd3);

    // T2 repeat: only req1
    tick(2);
    bus_d_in = 8'h44;
    req_tx1 = 8'h99;
    wq.push_back({16'hFF01, 8'h99});
    wq.push_back({16'hFF02, 8'h81});
    aq.push_back({2'b10, 8'h44, 1'b0});
    req = 2'b10;
    req_cyc = cyc;
    wait_acks(1'b0, ack_cnt + 1, 60, "t2_req1_ack_seen");
    req = 2'b00;
    check("t2_req1_immediate", 32'(last_sb_cyc - req_cyc), 32'd2);

    // T3: grant withheld for 10 cycles in ARB_SB
    tick(2);
    bus_gnt = 1'b0;
    bus_d_in = 8'h5E;
    req_tx0 = 8'h11;
    wq.push_back({16'hFF01, 8'h11});
    wq.push_back({16'hFF02, 8'h80});
    aq.push_back({2'b01, 8'h5E, 1'b0});
    req = 2'b01;
    w0 = wr_cnt;
    low_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      tick(1);
      if (!bus_req) low_cnt++;
    end
    check("t3_bus_req_held", 32'(low_cnt), 32'd0);
    check("t3_no_write_wo_gnt", 32'(wr_cnt - w0), 32'd0);
    bus_gnt = 1'b1;
    gnt_cyc = cyc;
    wait_acks(1'b0, ack_cnt + 1, 60, "t3_ack_seen");
    req = 2'b00;
    check("t3_write_after_gnt", 32'(last_sb_cyc - gnt_cyc), 32'd1);

    // T4: TIMEOUT = 16 instance, interrupt never rises
    link_auto = 1'b0;
    int_manual = 1'b0;
    tick(3);
    req_tx0 = 8'h77;
    req_intclk = 2'b00;
    twq.push_back({16'hFF01, 8'h77});
    twq.push_back({16'hFF02, 8'h80});
    twq.push_back({16'hFF02, 8'h00});
    taq.push_back({2'b01, 8'hFF, 1'b1});
    req_t = 2'b01;
    wait_acks(1'b1, 1, 60, "t4_ack_seen");
    req_t = 2'b00;
    check("t4_abort_window",
          32'((t_last_ack_cyc - t_last_sc_cyc >= 16) && (t_last_ack_cyc - t_last_sc_cyc <= 20)),
          32'd1);
    tick(3);
    check("t4_rx_hold", {23'h0, t_rx_data, t_timeout}, {23'h0, 8'hFF, 1'b1});

    // T5: int_serial already high before WAIT, then a fresh edge
    int_manual = 1'b1;
    tick(5);
    bus_d_in = 8'hC3;
    req_tx1 = 8'h5A;
    wq.push_back({16'hFF01, 8'h5A});
    wq.push_back({16'hFF02, 8'h80});
    aq.push_back({2'b10, 8'hC3, 1'b0});
    req = 2'b10;
    wait_sc(sc_cnt + 1, 20, "t5_sc_seen");
    a0 = ack_cnt;
    tick(20);
    check("t5_no_level_completion", 32'(ack_cnt), 32'(a0));
    int_manual = 1'b0;
    tick(3);
    int_manual = 1'b1;
    wait_acks(1'b0, a0 + 1, 30, "t5_ack_after_edge");
    req = 2'b00;

    // T6: reset during WAIT
    int_manual = 1'b0;
    tick(3);
    req_tx0 = 8'hE1;
    req_intclk = 2'b01;
    wq.push_back({16'hFF01, 8'hE1});
    wq.push_back({16'hFF02, 8'h81});
    req = 2'b01;
    wait_sc(sc_cnt + 1, 20, "t6_sc_seen");
    tick(5);
    nreset = 1'b0;
    #1;
    check("t6_rst_strobes", {27'h0, ack, timeout, bus_req, bus_wr, bus_rd}, 32'h0);
    check("t6_rst_rx_data", 32'(rx_data), 32'h0);
    check("t6_rst_bus_a_d", {8'h00, bus_a, bus_d_out}, 32'h0);
    req = 2'b00;
    tick(3);
    nreset = 1'b1;
    a0 = ack_cnt;
    tick(10);
    check("t6_no_ack_after_rst", 32'(ack_cnt), 32'(a0));

    link_auto = 1'b1;
    link_delay = 6;
    bus_d_in = 8'h96;
    req_tx0 = 8'h2B;
    req_intclk = 2'b00;
    wq.push_back({16'hFF01, 8'h2B});
    wq.push_back({16'hFF02, 8'h80});
    aq.push_back({2'b01, 8'h96, 1'b0});
    req = 2'b01;
    wait_acks(1'b0, ack_cnt + 1, 60, "t6_recover_ack_seen");
    req = 2'b00;
    tick(5);

    // All expectations consumed
    check("wq_drained", 32'(wq.size()), 32'd0);
    check("aq_drained", 32'(aq.size()), 32'd0);
    check("twq_drained", 32'(twq.size()), 32'd0);
    check("taq_drained", 32'(taq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
